muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request a multiply/divide when sampled high.
REQ-004 SHALL have port op, input, 2, operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL have port busA, input, 32, multiplicand/dividend.
REQ-006 SHALL have port busB, input, 32, multiplier/divisor.
REQ-007 SHALL have port hi_we, input, 1, MTHI write strobe, data taken from busA.
REQ-008 SHALL have port lo_we, input, 1, MTLO write strobe, data taken from busA.
REQ-009 SHALL have port flush, input, 1, abort of the in-flight operation.
REQ-010 SHALL have port busy, output, 1, high while an operation is in flight; the pipeline uses it as its stall.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port hi, output, 32, HI register.
REQ-013 SHALL have port lo, output, 32, LO register.

Function
REQ-014 SHALL implement the states IDLE, RUN and FIX; busy SHALL equal (state != IDLE).
REQ-015 In IDLE, start=1 SHALL latch op and the operand magnitudes (absolute values for MULT/DIV), record the result signs, clear the 5-bit iteration counter, and move to RUN.
REQ-016 In RUN, each edge SHALL perform one radix-2 step (shift-add for multiply, restoring shift-subtract for divide) and increment the counter; after step 32 (counter 31) the state SHALL move to FIX.
REQ-017 In FIX, the next edge SHALL write hi/lo with sign correction, pulse done for exactly one cycle, and return to IDLE.
REQ-018 Latency SHALL be 34 edges from the start edge until done is high: 32 RUN edges, then 1 FIX edge.
REQ-019 Multiply results SHALL be the 64-bit product, with HI holding the upper 32 bits and LO the lower 32 bits.
REQ-020 Divide results SHALL place the quotient in LO and the remainder in HI.
REQ-021 Signed divide SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-022 A divisor of zero SHALL skip RUN: the state goes IDLE to FIX, and FIX writes LO=FFFFFFFF and HI=dividend (raw busA); done follows 2 edges after start.
REQ-023 start while busy SHALL be ignored; no queueing.
REQ-024 hi_we/lo_we SHALL write HI/LO only in IDLE with start=0.
REQ-025 hi_we/lo_we SHALL be dropped while busy or in the same cycle as start, so start wins.
REQ-026 flush in RUN or FIX SHALL return to IDLE on that edge, leave HI/LO unchanged, and suppress done.
REQ-027 flush in IDLE SHALL have no effect; flush SHALL take priority over the FIX write.
REQ-028 hi and lo SHALL hold their values between writes.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0 and counter=0, including mid-operation.
REQ-030 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-031 The op encodings (MULTU/MULT/DIVU/DIV) and the state encodings SHALL live in the shared control-encoding definitions file alongside the ALUop codes.
REQ-032 One combinational sub-module muldiv_step SHALL compute a single iteration (partial remainder/product update) from the current registers and op.
REQ-033 Counter, state and the HI/LO registers SHALL stay in muldiv_seq.

Verification
REQ-034 MULTU busA=FFFFFFFF, busB=FFFFFFFF -> done exactly 34 edges after start, HI=FFFFFFFE, LO=00000001.
REQ-035 MULT busA=FFFFFFFD (-3), busB=00000007 -> HI=FFFFFFFF, LO=FFFFFFEB.
REQ-036 DIV busA=FFFFFFF9 (-7), busB=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-037 DIVU busA=00000005, busB=0 -> done 2 edges after start, HI=00000005, LO=FFFFFFFF.
REQ-038 MULTU started, flush at RUN edge 10 -> busy low the next cycle, done never pulses, HI/LO keep their prior values; a second start issued while busy is ignored.
REQ-039 rst_n low at RUN edge 20 -> busy=0, hi=0, lo=0 immediately; hi_we with busA=12345678 in IDLE -> HI=12345678 next cycle; hi_we simultaneous with start -> HI unchanged until done.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared control encodings for the execute stage: ALU op codes, multiply/divide
// op codes and the multiply/divide sequencer states.
package muldiv_seq_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOR  = 4'h5,
    ALU_SLT  = 4'h6,
    ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'hA,
    ALU_LUI  = 4'hB
  } alu_op_t;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_t;

  function automatic logic is_div_op(input mdu_op_t o);
    return (o == OP_DIVU) || (o == OP_DIV);
  endfunction

  function automatic logic is_signed_op(input mdu_op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide
// on the {acc_hi, acc_lo} working pair.
module muldiv_step
  import muldiv_seq_pkg::*;
(
  input  logic        is_div,
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
  input  logic [31:0] opnd,
  output logic [31:0] nxt_hi,
  output logic [31:0] nxt_lo
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic        fits;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
    shifted = {acc_hi, acc_lo[31]};
    fits    = (shifted >= {1'b0, opnd});
    nxt_hi  = '0;
    nxt_lo  = '0;
    if (is_div) begin
      // Remainder stays below the divisor, so a 32-bit difference is exact.
      nxt_hi = fits ? (shifted[31:0] - opnd) : shifted[31:0];
      nxt_lo = {acc_lo[30:0], fits};
    end else begin
      nxt_hi = sum[32:1];
      nxt_lo = {sum[0], acc_lo[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32-bit multiply/divide unit with HI/LO result registers,
// 32-step radix-2 iteration followed by a sign-fix cycle.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t  state, state_nxt;
  mdu_op_t     op_in, op_q;
  logic [4:0]  cnt;
  logic [31:0] acc_hi, acc_lo, opnd;
  logic        neg_hi, neg_lo;
  logic [31:0] step_hi, step_lo;
  logic        a_neg, b_neg, div0;
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod_fix;
  logic [31:0] fix_hi, fix_lo;

  assign op_in = mdu_op_t'(op);
  assign busy  = (state != ST_IDLE);

  always_comb begin
    a_neg = is_signed_op(op_in) & busA[31];
    b_neg = is_signed_op(op_in) & busB[31];
    mag_a = a_neg ? (~busA + 32'd1) : busA;
    mag_b = b_neg ? (~busB + 32'd1) : busB;
    div0  = is_div_op(op_in) && (busB == '0);
  end

  muldiv_step u_step (
    .is_div (is_div_op(op_q)),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  always_comb begin
    prod_fix = neg_lo ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
    fix_hi   = prod_fix[63:32];
    fix_lo   = prod_fix[31:0];
    if (is_div_op(op_q)) begin
      fix_lo = neg_lo ? (~acc_lo + 32'd1) : acc_lo;
      fix_hi = neg_hi ? (~acc_hi + 32'd1) : acc_hi;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = div0 ? ST_FIX : ST_RUN;
      ST_RUN: begin
        if (flush)               state_nxt = ST_IDLE;
        else if (cnt == 5'd31)   state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MULTU;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= op_in;
            cnt  <= '0;
            if (div0) begin
              // Preload the final results so FIX writes them with no correction.
              acc_hi <= busA;
              acc_lo <= '1;
              opnd   <= '0;
              neg_hi <= 1'b0;
              neg_lo <= 1'b0;
            end else if (is_div_op(op_in)) begin
              acc_hi <= '0;
              acc_lo <= mag_a;
              opnd   <= mag_b;
              neg_hi <= a_neg;
              neg_lo <= a_neg ^ b_neg;
            end else begin
              acc_hi <= '0;
              acc_lo <= mag_b;
              opnd   <= mag_a;
              neg_hi <= a_neg ^ b_neg;
              neg_lo <= a_neg ^ b_neg;
            end
          end else begin
            if (hi_we) hi <= busA;
            if (lo_we) lo <= busA;
          end
        end
        ST_RUN: begin
          if (!flush) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 5'd1;
          end
        end
        ST_FIX: begin
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
